// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset control unit: FSM states,
// opcode/funct constants and the alu_control codes also used by `alu`.
package mc_pkg;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_RTEXE  = 4'd7,
        S_RTWB   = 4'd8,
        S_BRANCH = 4'd9,
        S_ITEXE  = 4'd10,
        S_ITWB   = 4'd11,
        S_JUMP   = 4'd12
    } state_t;

    // How the ALU operation is chosen in a given state.
    typedef enum logic [1:0] {
        ACLS_ADD   = 2'd0,
        ACLS_SUB   = 2'd1,
        ACLS_RTYPE = 2'd2,
        ACLS_ITYPE = 2'd3
    } alu_class_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_NOR  = 3'b010;
    localparam logic [2:0] ALU_AND  = 3'b011;
    localparam logic [2:0] ALU_OR   = 3'b100;
    localparam logic [2:0] ALU_SLT  = 3'b111;

    function automatic logic is_itype_alu(input logic [5:0] op);
        return (op == OP_ADDI) || (op == OP_SLTI) || (op == OP_ANDI) || (op == OP_ORI);
    endfunction

    function automatic logic opcode_legal(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_J)  || (op == OP_BEQ) || (op == OP_BNE) ||
               (op == OP_LW)    || (op == OP_SW) || is_itype_alu(op);
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU-control decode: (state class, opcode, funct) to
// alu_control, immediate extension mode and the R-type funct-legal flag.
module alu_decoder
    import mc_pkg::*;
(
    input  logic [1:0] alu_class,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [2:0] alu_control,
    output logic       ext_zero,
    output logic       funct_legal
);

    logic [2:0] w_rtype_op;
    logic       w_rtype_ok;
    logic [2:0] w_itype_op;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_rtype_op = ALU_ADD;
        w_rtype_ok = 1'b1;
        case (funct)
            FN_ADD, FN_ADDU: w_rtype_op = ALU_ADD;
            FN_SUB:          w_rtype_op = ALU_SUB;
            FN_AND:          w_rtype_op = ALU_AND;
            FN_OR:           w_rtype_op = ALU_OR;
            FN_NOR:          w_rtype_op = ALU_NOR;
            FN_SLT:          w_rtype_op = ALU_SLT;
            default:         w_rtype_ok = 1'b0;
        endcase
    end

    always_comb begin
        w_itype_op = ALU_ADD;
        case (opcode)
            OP_SLTI: w_itype_op = ALU_SLT;
            OP_ANDI: w_itype_op = ALU_AND;
            OP_ORI:  w_itype_op = ALU_OR;
            default: w_itype_op = ALU_ADD;
        endcase
    end

    always_comb begin
        alu_control = ALU_ADD;
        ext_zero    = 1'b0;
        case (alu_class)
            ACLS_SUB:   alu_control = ALU_SUB;
            ACLS_RTYPE: alu_control = w_rtype_op;
            ACLS_ITYPE: begin
                alu_control = w_itype_op;
                ext_zero    = (opcode == OP_ANDI) || (opcode == OP_ORI);
            end
            default:    alu_control = ALU_ADD;
        endcase
    end

    assign funct_legal = w_rtype_ok;

endmodule

// File: rtl/mc_control.sv
// Multi-cycle MIPS-subset control FSM (Moore; only BRANCH pc_write sees zero).
// Define MC_MEM_WAIT_EN to add mem_ready and stall FETCH/MEMRD/MEMWR on it.
module mc_control
    import mc_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
`ifdef MC_MEM_WAIT_EN
    input  logic       mem_ready,
`endif
    output logic       pc_write,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       ext_zero,
    output logic [1:0] pc_src,
    output logic [2:0] alu_control,
    output logic       illegal,
    output logic [3:0] state
);

    state_t     r_state;
    alu_class_t w_alu_class;
    logic       w_mem_ready;
    logic       w_funct_legal;
    logic       w_illegal;
    logic       w_dec_ext_zero;
    logic [2:0] w_dec_alu_control;

`ifdef MC_MEM_WAIT_EN
    assign w_mem_ready = mem_ready;
`else
    assign w_mem_ready = 1'b1;
`endif

    // Only meaningful while in DECODE, where opcode/funct are valid.
    assign w_illegal = !opcode_legal(opcode) || ((opcode == OP_RTYPE) && !w_funct_legal);

    always_comb begin
        w_alu_class = ACLS_ADD;
        case (r_state)
            S_RTEXE:  w_alu_class = ACLS_RTYPE;
            S_ITEXE:  w_alu_class = ACLS_ITYPE;
            S_BRANCH: w_alu_class = ACLS_SUB;
            default:  w_alu_class = ACLS_ADD;
        endcase
    end

    alu_decoder u_alu_decoder (
        .alu_class   (w_alu_class),
        .opcode      (opcode),
        .funct       (funct),
        .alu_control (w_dec_alu_control),
        .ext_zero    (w_dec_ext_zero),
        .funct_legal (w_funct_legal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:   r_state <= S_FETCH;
                S_FETCH:  if (w_mem_ready) r_state <= S_DECODE;
                S_DECODE: begin
                    if (w_illegal) begin
                        r_state <= S_FETCH;
                    end else begin
                        case (opcode)
                            OP_LW, OP_SW:                      r_state <= S_MEMADR;
                            OP_RTYPE:                          r_state <= S_RTEXE;
                            OP_BEQ, OP_BNE:                    r_state <= S_BRANCH;
                            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: r_state <= S_ITEXE;
                            OP_J:                              r_state <= S_JUMP;
                            default:                           r_state <= S_FETCH;
                        endcase
                    end
                end
                S_MEMADR: r_state <= (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
                S_MEMRD:  if (w_mem_ready) r_state <= S_MEMWB;
                S_MEMWR:  if (w_mem_ready) r_state <= S_FETCH;
                S_RTEXE:  r_state <= S_RTWB;
                S_ITEXE:  r_state <= S_ITWB;
                S_MEMWB, S_RTWB, S_ITWB, S_BRANCH, S_JUMP: r_state <= S_FETCH;
                default:  r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        pc_write   = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        pc_src     = 2'b00;
        illegal    = 1'b0;
        case (r_state)
            S_FETCH: begin
                mem_read  = 1'b1;
                ir_write  = w_mem_ready;
                pc_write  = w_mem_ready;
                alu_src_b = 2'b01;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                illegal   = w_illegal;
            end
            S_MEMADR, S_ITEXE: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
            end
            S_RTEXE:  alu_src_a = 1'b1;
            S_RTWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                pc_src    = 2'b01;
                pc_write  = (opcode == OP_BEQ) ? zero : ~zero;
            end
            S_ITWB:   reg_write = 1'b1;
            S_JUMP: begin
                pc_src   = 2'b10;
                pc_write = 1'b1;
            end
            default: ;
        endcase
    end

    assign ext_zero    = w_dec_ext_zero;
    assign alu_control = w_dec_alu_control;
    assign state       = r_state;

endmodule

// File: tb/tb_mc_control.sv
// Directed bench for mc_control: per-cycle state and control-vector checks.
module tb_mc_control;
    import mc_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
`ifdef MC_MEM_WAIT_EN
    logic       mem_ready;
`endif
    logic       pc_write, iord, mem_read, mem_write, ir_write;
    logic       reg_dst, mem_to_reg, reg_write, alu_src_a, ext_zero, illegal;
    logic [1:0] alu_src_b, pc_src;
    logic [2:0] alu_control;
    logic [3:0] state;

    int n_checks = 0;
    int n_pass   = 0;

    mc_control dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .opcode      (opcode),
        .funct       (funct),
        .zero        (zero),
`ifdef MC_MEM_WAIT_EN
        .mem_ready   (mem_ready),
`endif
        .pc_write    (pc_write),
        .iord        (iord),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .ir_write    (ir_write),
        .reg_dst     (reg_dst),
        .mem_to_reg  (mem_to_reg),
        .reg_write   (reg_write),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .ext_zero    (ext_zero),
        .pc_src      (pc_src),
        .alu_control (alu_control),
        .illegal     (illegal),
        .state       (state)
    );

    always #5 clk = ~clk;

    // {pc_write,iord,mem_read,mem_write,ir_write,reg_dst,mem_to_reg,reg_write,
    //  alu_src_a,alu_src_b[1:0],ext_zero,pc_src[1:0],alu_control[2:0],illegal}
    logic [17:0] w_ctl;
    assign w_ctl = {pc_write, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
                    reg_write, alu_src_a, alu_src_b, ext_zero, pc_src, alu_control, illegal};

    localparam logic [17:0] V_IDLE     = 18'b0_0_0_0_0_0_0_0_0_00_0_00_000_0;
    localparam logic [17:0] V_FETCH    = 18'b1_0_1_0_1_0_0_0_0_01_0_00_000_0;
    localparam logic [17:0] V_DECODE   = 18'b0_0_0_0_0_0_0_0_0_11_0_00_000_0;
    localparam logic [17:0] V_DEC_ILL  = 18'b0_0_0_0_0_0_0_0_0_11_0_00_000_1;
    localparam logic [17:0] V_MEMADR   = 18'b0_0_0_0_0_0_0_0_1_10_0_00_000_0;
    localparam logic [17:0] V_MEMRD    = 18'b0_1_1_0_0_0_0_0_0_00_0_00_000_0;
    localparam logic [17:0] V_MEMWB    = 18'b0_0_0_0_0_0_1_1_0_00_0_00_000_0;
    localparam logic [17:0] V_MEMWR    = 18'b0_1_0_1_0_0_0_0_0_00_0_00_000_0;
    localparam logic [17:0] V_RT_SLT   = 18'b0_0_0_0_0_0_0_0_1_00_0_00_111_0;
    localparam logic [17:0] V_RT_SUB   = 18'b0_0_0_0_0_0_0_0_1_00_0_00_001_0;
    localparam logic [17:0] V_RTWB     = 18'b0_0_0_0_0_1_0_1_0_00_0_00_000_0;
    localparam logic [17:0] V_BR_TAKEN = 18'b1_0_0_0_0_0_0_0_1_00_0_01_001_0;
    localparam logic [17:0] V_BR_NOT   = 18'b0_0_0_0_0_0_0_0_1_00_0_01_001_0;
    localparam logic [17:0] V_IT_ORI   = 18'b0_0_0_0_0_0_0_0_1_10_1_00_100_0;
    localparam logic [17:0] V_IT_ADDI  = 18'b0_0_0_0_0_0_0_0_1_10_0_00_000_0;
    localparam logic [17:0] V_ITWB     = 18'b0_0_0_0_0_0_0_1_0_00_0_00_000_0;
    localparam logic [17:0] V_JUMP     = 18'b1_0_0_0_0_0_0_0_0_00_0_10_000_0;
`ifdef MC_MEM_WAIT_EN
    localparam logic [17:0] V_FETCH_WT = 18'b0_0_1_0_0_0_0_0_0_01_0_00_000_0;
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Check the current cycle's state and controls, then move one cycle on.
    task automatic expect_cycle(input string tag, input state_t st, input logic [17:0] vec);
        #1;
        check({tag, " state"}, 32'(state), 32'(st));
        check({tag, " ctl"}, 32'(w_ctl), 32'(vec));
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [5:0] op, input logic [5:0] fn, input logic z);
        opcode = op;
        funct  = fn;
        zero   = z;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n  = 1'b0;
        opcode = 6'h00;
        funct  = 6'h00;
        zero   = 1'b0;
`ifdef MC_MEM_WAIT_EN
        mem_ready = 1'b1;
`endif
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) expect_cycle("reset", S_IDLE, V_IDLE);
        rst_n = 1'b1;
        expect_cycle("idle", S_IDLE, V_IDLE);

        set_instr(OP_RTYPE, FN_SLT, 1'b0);
        expect_cycle("slt fetch", S_FETCH, V_FETCH);
        expect_cycle("slt decode", S_DECODE, V_DECODE);
        expect_cycle("slt exe", S_RTEXE, V_RT_SLT);
        expect_cycle("slt wb", S_RTWB, V_RTWB);

        set_instr(OP_RTYPE, FN_SUB, 1'b0);
        expect_cycle("sub fetch", S_FETCH, V_FETCH);
        expect_cycle("sub decode", S_DECODE, V_DECODE);
        expect_cycle("sub exe", S_RTEXE, V_RT_SUB);
        expect_cycle("sub wb", S_RTWB, V_RTWB);

        set_instr(OP_LW, 6'h00, 1'b0);
        expect_cycle("lw fetch", S_FETCH, V_FETCH);
        expect_cycle("lw decode", S_DECODE, V_DECODE);
        expect_cycle("lw memadr", S_MEMADR, V_MEMADR);
        expect_cycle("lw memrd", S_MEMRD, V_MEMRD);
        expect_cycle("lw memwb", S_MEMWB, V_MEMWB);

        set_instr(OP_SW, 6'h00, 1'b0);
        expect_cycle("sw fetch", S_FETCH, V_FETCH);
        expect_cycle("sw decode", S_DECODE, V_DECODE);
        expect_cycle("sw memadr", S_MEMADR, V_MEMADR);
        expect_cycle("sw memwr", S_MEMWR, V_MEMWR);

        set_instr(OP_BEQ, 6'h00, 1'b1);
        expect_cycle("beq z1 fetch", S_FETCH, V_FETCH);
        expect_cycle("beq z1 decode", S_DECODE, V_DECODE);
        expect_cycle("beq z1 branch", S_BRANCH, V_BR_TAKEN);

        set_instr(OP_BNE, 6'h00, 1'b1);
        expect_cycle("bne z1 fetch", S_FETCH, V_FETCH);
        expect_cycle("bne z1 decode", S_DECODE, V_DECODE);
        expect_cycle("bne z1 branch", S_BRANCH, V_BR_NOT);

        set_instr(OP_BEQ, 6'h00, 1'b0);
        expect_cycle("beq z0 fetch", S_FETCH, V_FETCH);
        expect_cycle("beq z0 decode", S_DECODE, V_DECODE);
        expect_cycle("beq z0 branch", S_BRANCH, V_BR_NOT);

        set_instr(OP_BNE, 6'h00, 1'b0);
        expect_cycle("bne z0 fetch", S_FETCH, V_FETCH);
        expect_cycle("bne z0 decode", S_DECODE, V_DECODE);
        expect_cycle("bne z0 branch", S_BRANCH, V_BR_TAKEN);

        set_instr(OP_ORI, 6'h00, 1'b0);
        expect_cycle("ori fetch", S_FETCH, V_FETCH);
        expect_cycle("ori decode", S_DECODE, V_DECODE);
        expect_cycle("ori exe", S_ITEXE, V_IT_ORI);
        expect_cycle("ori wb", S_ITWB, V_ITWB);

        set_instr(OP_ADDI, 6'h00, 1'b0);
        expect_cycle("addi fetch", S_FETCH, V_FETCH);
        expect_cycle("addi decode", S_DECODE, V_DECODE);
        expect_cycle("addi exe", S_ITEXE, V_IT_ADDI);
        expect_cycle("addi wb", S_ITWB, V_ITWB);

        set_instr(6'h3F, 6'h00, 1'b0);
        expect_cycle("badop fetch", S_FETCH, V_FETCH);
        expect_cycle("badop decode", S_DECODE, V_DEC_ILL);

        set_instr(OP_RTYPE, 6'h3F, 1'b0);
        expect_cycle("badfn fetch", S_FETCH, V_FETCH);
        expect_cycle("badfn decode", S_DECODE, V_DEC_ILL);

        set_instr(OP_J, 6'h00, 1'b0);
        expect_cycle("j fetch", S_FETCH, V_FETCH);
        expect_cycle("j decode", S_DECODE, V_DECODE);
        expect_cycle("j jump", S_JUMP, V_JUMP);

`ifdef MC_MEM_WAIT_EN
        set_instr(OP_LW, 6'h00, 1'b0);
        mem_ready = 1'b0;
        expect_cycle("wait fetch stall", S_FETCH, V_FETCH_WT);
        mem_ready = 1'b1;
        expect_cycle("wait fetch go", S_FETCH, V_FETCH);
        expect_cycle("wait decode", S_DECODE, V_DECODE);
        expect_cycle("wait memadr", S_MEMADR, V_MEMADR);
        mem_ready = 1'b0;
        expect_cycle("wait memrd 1", S_MEMRD, V_MEMRD);
        expect_cycle("wait memrd 2", S_MEMRD, V_MEMRD);
        mem_ready = 1'b1;
        expect_cycle("wait memrd go", S_MEMRD, V_MEMRD);
        expect_cycle("wait memwb", S_MEMWB, V_MEMWB);

        set_instr(OP_SW, 6'h00, 1'b0);
        expect_cycle("wait sw fetch", S_FETCH, V_FETCH);
        expect_cycle("wait sw decode", S_DECODE, V_DECODE);
        expect_cycle("wait sw memadr", S_MEMADR, V_MEMADR);
        mem_ready = 1'b0;
        expect_cycle("wait sw memwr 1", S_MEMWR, V_MEMWR);
        mem_ready = 1'b1;
        expect_cycle("wait sw memwr go", S_MEMWR, V_MEMWR);
`endif

        // Reset in the middle of a load must drop straight back to IDLE.
        set_instr(OP_LW, 6'h00, 1'b0);
        expect_cycle("rst lw fetch", S_FETCH, V_FETCH);
        expect_cycle("rst lw decode", S_DECODE, V_DECODE);
        expect_cycle("rst lw memadr", S_MEMADR, V_MEMADR);
`ifdef MC_MEM_WAIT_EN
        mem_ready = 1'b0;
`endif
        #1;
        check("rst lw memrd state", 32'(state), 32'(S_MEMRD));
        rst_n = 1'b0;
        #1;
        check("async rst state", 32'(state), 32'(S_IDLE));
        check("async rst ctl", 32'(w_ctl), 32'(V_IDLE));
        @(posedge clk);
        #1;
`ifdef MC_MEM_WAIT_EN
        mem_ready = 1'b1;
`endif
        rst_n = 1'b1;
        expect_cycle("post rst idle", S_IDLE, V_IDLE);
        expect_cycle("post rst fetch", S_FETCH, V_FETCH);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
